led_indicator: RTL

- Output-side human-interface block: turns single-cycle logic commands into human-visible LED activity.
- Supported patterns: steady on/off, N-blink sequence, minimum-duration flash.
- Sits between the control logic (which consumes debounced button events) and a board LED pin.
- Timing uses a shared tick prescaler, so LED phases have exact, human-scale durations.

---
 rtl/led_indicator.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/led_indicator.sv
// rtl/led_indicator.sv - LED pattern generator: steady on/off, N-blink and minimum-duration flash
//
// Purpose: turns single-cycle commands from control logic into human-visible
// LED activity with tick-exact phase durations.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset (0 = reset)
//   cmd_valid  command present
//   cmd_ready  command can be accepted this cycle (S_OFF / S_ON only)
//   cmd_mode   00 off, 01 steady on, 10 blink cmd_count times, 11 flash
//   cmd_count  blink count for mode 10
//   led        registered LED drive, active-high
//   busy       timed sequence (blink or flash) in progress
//   done       one-cycle pulse when a timed sequence completes
module led_indicator #(
    parameter int TICK_CYCLES   = 1000000,
    parameter int BLINK_TICKS   = 10,
    parameter int STRETCH_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    output logic       led,
    output logic       busy,
    output logic       done
);

    localparam int PRES_W = $clog2(TICK_CYCLES);
    localparam int PH_MAX = (BLINK_TICKS > STRETCH_TICKS) ? BLINK_TICKS : STRETCH_TICKS;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PRES_W-1:0] PRES_TOP  = PRES_W'(TICK_CYCLES - 1);
    localparam logic [PH_W-1:0]   BLINK_TOP = PH_W'(BLINK_TICKS - 1);
    localparam logic [PH_W-1:0]   FLASH_TOP = PH_W'(STRETCH_TICKS - 1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_ON        = 3'd1,
        S_BLINK_ON  = 3'd2,
        S_BLINK_OFF = 3'd3,
        S_FLASH     = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [PRES_W-1:0] pres, pres_d;
    logic [PH_W-1:0]   phase, phase_d;
    logic [3:0]        blink, blink_d;
    logic              led_d, busy_d, done_d;

    logic accept;
    logic tick;
    logic phase_end;

    assign cmd_ready = (state == S_OFF) || (state == S_ON);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (pres == '0);
    assign phase_end = tick && (phase == '0);

    // State and datapath register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_OFF;
            pres  <= PRES_TOP;
            phase <= '0;
            blink <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            pres  <= pres_d;
            phase <= phase_d;
            blink <= blink_d;
            led   <= led_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state;
        blink_d = blink;
        done_d  = 1'b0;
        phase_d = (tick && (phase != '0)) ? phase - 1'b1 : phase;

        // Every accepted command restarts the tick grid so the first phase is full length
        if (accept || tick) begin
            pres_d = PRES_TOP;
        end else begin
            pres_d = pres - 1'b1;
        end

        case (state)
            S_OFF, S_ON: begin
                if (accept) begin
                    case (cmd_mode)
                        2'b00: state_d = S_OFF;
                        2'b01: state_d = S_ON;
                        2'b10: begin
                            if (cmd_count != 4'd0) begin
                                state_d = S_BLINK_ON;
                                blink_d = cmd_count;
                                phase_d = BLINK_TOP;
                            end else begin
                                // Empty blink sequence completes immediately
                                state_d = S_OFF;
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            // Flash always ends in S_OFF, even if launched from S_ON
                            state_d = S_FLASH;
                            phase_d = FLASH_TOP;
                        end
                    endcase
                end
            end
            S_BLINK_ON: begin
                if (phase_end) begin
                    state_d = S_BLINK_OFF;
                    blink_d = blink - 4'd1;
                    phase_d = BLINK_TOP;
                end
            end
            S_BLINK_OFF: begin
                if (phase_end) begin
                    if (blink == 4'd0) begin
                        state_d = S_OFF;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BLINK_ON;
                        phase_d = BLINK_TOP;
                    end
                end
            end
            S_FLASH: begin
                if (phase_end) begin
                    state_d = S_OFF;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // Registered outputs are decoded from the next state
    always_comb begin
        led_d  = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            S_ON:        led_d = 1'b1;
            S_BLINK_ON:  begin led_d = 1'b1; busy_d = 1'b1; end
            S_BLINK_OFF: busy_d = 1'b1;
            S_FLASH:     begin led_d = 1'b1; busy_d = 1'b1; end
            default:     led_d = 1'b0;
        endcase
    end

endmodule
